// File: rtl/servo_pwm_gen.sv
// Servo PWM frame generator: commanded high-time is clamped, held pending, and applied only at frame boundaries.
// Optional macro SERVO_SLEW_LIMIT_EN limits each boundary update to MAX_STEP cycles of high-time.
module servo_pwm_gen #(
    parameter int PERIOD      = 1000000,
    parameter int MIN_DUTY    = 50000,
    parameter int MAX_DUTY    = 100000,
    parameter int CENTER_DUTY = 75000,
    parameter int MAX_STEP    = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [17:0] duty_in,
    input  logic        duty_valid,
    output logic        pwm_out,
    output logic [17:0] duty_active,
    output logic        frame_start,
    output logic        clamped,
    output logic        running
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CMP_W = (CNT_W > 18) ? CNT_W : 18;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [17:0]      DUTY_MIN   = 18'(MIN_DUTY);
    localparam logic [17:0]      DUTY_MAX   = 18'(MAX_DUTY);
    localparam logic [17:0]      DUTY_CTR   = 18'(CENTER_DUTY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [17:0]      pending;
    logic             pend_flag;
    logic [17:0]      duty_clamped;
    logic             clamp_hit;
    logic [17:0]      duty_load;
    logic             load_done;
    logic             boundary;
    logic             start_run;
    logic             load_evt;

    always_comb begin
        state_nxt   = state;
        running     = 1'b0;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                running = 1'b1;
                if (!en) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                running = 1'b1;
                if (en)
                    state_nxt = ST_RUN;
                else if (cnt == CNT_LAST)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (running && cnt == '0) frame_start = 1'b1;
    end

    assign boundary  = (state != ST_IDLE) && (cnt == CNT_LAST);
    assign start_run = (state == ST_IDLE) && en;
    assign load_evt  = boundary || start_run;

    always_comb begin
        duty_clamped = duty_in;
        clamp_hit    = 1'b0;
        if (duty_in < DUTY_MIN) begin
            duty_clamped = DUTY_MIN;
            clamp_hit    = duty_valid;
        end else if (duty_in > DUTY_MAX) begin
            duty_clamped = DUTY_MAX;
            clamp_hit    = duty_valid;
        end
    end

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic [17:0] STEP = 18'(MAX_STEP);

    always_comb begin
        duty_load = pending;
        if (pending > duty_active) begin
            if (pending - duty_active > STEP) duty_load = duty_active + STEP;
        end else if (duty_active - pending > STEP) begin
            duty_load = duty_active - STEP;
        end
    end
`else
    assign duty_load = pending;

    // MAX_STEP only matters when slew limiting is compiled in.
    if (MAX_STEP < 0) begin : g_max_step_unused
    end
`endif

    assign load_done = (duty_load == pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pwm_out     <= 1'b0;
            clamped     <= 1'b0;
            pend_flag   <= 1'b0;
            pending     <= DUTY_CTR;
            duty_active <= DUTY_CTR;
        end else begin
            state <= state_nxt;

            if (state == ST_IDLE || cnt == CNT_LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            // A sample arriving on a load cycle is not seen by that load.
            if (load_evt) begin
                if (pend_flag)
                    duty_active <= duty_load;
                else if (start_run)
                    duty_active <= DUTY_CTR;
            end

            if (duty_valid) begin
                pending   <= duty_clamped;
                pend_flag <= 1'b1;
            end else if (load_evt && pend_flag && load_done) begin
                pend_flag <= 1'b0;
            end

            pwm_out <= running && (CMP_W'(cnt) < CMP_W'(duty_active));
            clamped <= clamp_hit;
        end
    end

endmodule

// File: doc/servo_pwm_gen.md
SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 SHALL have parameter PERIOD, default 1000000, meaning clk cycles per PWM frame (20 ms at 50 MHz).
REQ-002 SHALL have parameter MIN_DUTY, default 50000, meaning the lowest legal high-time in cycles (0 deg).
REQ-003 SHALL have parameter MAX_DUTY, default 100000, meaning the highest legal high-time in cycles (180 deg).
REQ-004 SHALL have parameter CENTER_DUTY, default 75000, meaning the high-time used when no command is pending (90 deg).
REQ-005 SHALL have parameter MAX_STEP, default 500, meaning the maximum high-time change per frame when slew limiting is compiled in.
REQ-006 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port en, input, 1, level; 1 requests PWM generation.
REQ-009 SHALL have port duty_in, input, 18, unsigned commanded high-time from the PID stage.
REQ-010 SHALL have port duty_valid, input, 1, qualifies duty_in for one cycle.
REQ-011 SHALL have port pwm_out, output, 1, registered servo drive signal.
REQ-012 SHALL have port duty_active, output, 18, high-time applied in the current frame.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse in the cycle where the counter equals 0 while running.
REQ-014 SHALL have port clamped, output, 1, one-cycle pulse, registered, one cycle after a duty_valid sample that was clamped.
REQ-015 SHALL have port running, output, 1, high in the RUN and DRAIN states.

Function
REQ-016 SHALL implement the states IDLE, RUN and DRAIN.
REQ-017 Transitions SHALL be: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->RUN when en=1; DRAIN->IDLE when cnt=PERIOD-1 and en=0.
REQ-018 SHALL keep a frame counter cnt of ceil(log2(PERIOD)) bits, held at 0 in IDLE, and incrementing in RUN/DRAIN from 0 to PERIOD-1 before wrapping to 0.
REQ-019 On a duty_valid sample, SHALL clamp duty_in to [MIN_DUTY, MAX_DUTY], store it in a pending register and set pend_flag; the last sample in a frame wins.
REQ-020 At a frame boundary (cnt=PERIOD-1 in RUN/DRAIN), and on the IDLE->RUN transition, SHALL load duty_active from the pending register if pend_flag=1 and then clear pend_flag; otherwise duty_active is unchanged.
REQ-021 On IDLE->RUN with pend_flag=0, SHALL load duty_active with CENTER_DUTY.
REQ-022 When duty_valid coincides with a boundary load, the load SHALL use the prior pending value; the new sample SHALL be pending for the next boundary.
REQ-023 pwm_out SHALL register (running && cnt < duty_active), with one cycle of latency from cnt, giving exactly duty_active high cycles per frame.
REQ-024 duty_active SHALL change only at frame boundaries, so no frame is ever truncated or glitched.
REQ-025 en falling mid-frame SHALL complete the current frame (DRAIN); pwm_out SHALL be 0 from the first cycle after the return to IDLE.
REQ-026 en toggling 1->0->1 within one frame SHALL produce no visible interruption of frames.
REQ-027 Comparisons SHALL be unsigned; clamping SHALL be performed on the full 18-bit value before storage.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state=IDLE, cnt=0, pwm_out=0, frame_start=0, clamped=0, running=0, pend_flag=0, pending=CENTER_DUTY, duty_active=CENTER_DUTY.
REQ-029 Reset mid-frame SHALL drop pwm_out to 0 immediately; after release, operation SHALL resume from IDLE.

Configuration
REQ-030 Macro SERVO_SLEW_LIMIT_EN, when defined, SHALL make each boundary load move duty_active toward the pending value by at most MAX_STEP, keeping pend_flag set until the target is reached.
REQ-031 Without SERVO_SLEW_LIMIT_EN, the boundary load SHALL copy the pending value directly; MAX_STEP SHALL be unused.

Verification (bench overrides: PERIOD=1000, MIN_DUTY=50, MAX_DUTY=100, CENTER_DUTY=75, MAX_STEP=5)
REQ-032 Reset, then en=1 with no command -> frame_start every 1000 cycles; pwm_out high for 75 cycles per frame.
REQ-033 duty_valid with duty_in=90 at mid-frame -> current frame stays at 75; next frame high for 90 cycles; duty_active=90.
REQ-034 duty_in=20, then duty_in=200000 -> clamped pulses for both samples; frames at 50 and 100 respectively.
REQ-035 en=0 at cnt=300 -> frame completes, running falls after cnt=999, and pwm_out stays 0 thereafter.
REQ-036 rst_n asserted at cnt=40 while pwm_out=1 -> pwm_out=0 asynchronously and all outputs at reset values.
REQ-037 With SERVO_SLEW_LIMIT_EN, command 90 from 75 -> successive frames at 80, 85, 90; without the macro -> 90 in the first new frame.
